// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_ADC   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SBB   = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_NOT   = 5'b00111;
    localparam logic [4:0] OP_SHL   = 5'b01000;
    localparam logic [4:0] OP_SHR   = 5'b01001;
    localparam logic [4:0] OP_ROL   = 5'b01010;
    localparam logic [4:0] OP_ROR   = 5'b01011;
    localparam logic [4:0] OP_INC   = 5'b01100;
    localparam logic [4:0] OP_DEC   = 5'b01101;
    localparam logic [4:0] OP_PASS  = 5'b01110;
    localparam logic [4:0] OP_LOAD  = 5'b01111;
    localparam logic [4:0] OP_STORE = 5'b10000;
    localparam logic [4:0] OP_CMP   = 5'b10001;
    localparam logic [4:0] OP_MUL   = 5'b11000;
    localparam logic [4:0] OP_DIV   = 5'b11001;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;
    localparam int FLG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per clock, WIDTH steps.
// The first step is taken on the start edge, so done rises WIDTH-1 edges later and holds.
module iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             div_q;
    logic [WIDTH-1:0] d_q;

    logic             cur_div;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_d;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        cur_div = start ? is_div : div_q;
        cur_hi  = start ? '0 : hi;
        cur_lo  = start ? a : lo;
        cur_d   = start ? b : d_q;

        // multiply: add multiplicand on lsb, then shift {carry,hi,lo} right
        msum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_d} : '0);

        // divide: shift next dividend bit into the partial remainder and trial-subtract
        shifted = {cur_hi, cur_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, cur_d});
        diff    = shifted[WIDTH-1:0] - cur_d;

        if (cur_div) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = msum[WIDTH:1];
            nxt_lo = {msum[0], cur_lo[WIDTH-1:1]};
        end
    end

    assign done = (cnt == CW'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            d_q   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            cnt   <= CW'(1);
            hi    <= nxt_hi;
            lo    <= nxt_lo;
            d_q   <= b;
            div_q <= is_div;
        end else if (cnt != '0 && !done) begin
            cnt <= cnt + CW'(1);
            hi  <= nxt_hi;
            lo  <= nxt_lo;
        end
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// EX-stage ALU: single-cycle ops registered on acceptance, MUL/DIV via iterator,
// persistent flag register, valid/ready on both sides.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 5,
    parameter int MD_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] data_out,
    output logic [3:0]       flags,
    output logic             err
);

    state_t state_q, state_d;

    logic             accept, is_md, md_start, md_is_div, md_done, md_fire, busy_div;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [3:0]       md_flags;

    logic             arith, sub, set_lf, shc, ci, c_err;
    logic [WIDTH-1:0] opb, lres, c_res, c_hi;
    logic [WIDTH:0]   ext;
    logic [3:0]       c_flags;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    // DIV by zero is resolved in the single-cycle path
    assign is_md     = (MD_EN != 0) && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    assign md_start  = accept && is_md;
    assign md_is_div = (op == OP_DIV);
    assign md_fire   = (state_q == ST_BUSY) && md_done && (!out_valid || out_ready);

    generate
        if (MD_EN != 0) begin : g_md
            iter_muldiv #(.WIDTH(WIDTH)) u_md (
                .clk    (clk),
                .rst    (rst),
                .start  (md_start),
                .is_div (md_is_div),
                .a      (a),
                .b      (b),
                .done   (md_done),
                .lo     (md_lo),
                .hi     (md_hi)
            );
        end else begin : g_no_md
            logic md_unused;
            assign md_unused = md_start ^ md_is_div;
            assign md_done   = 1'b0;
            assign md_lo     = '0;
            assign md_hi     = '0;
        end
    endgenerate

    always_comb begin
        md_flags = 4'b0000;
        if (busy_div) begin
            md_flags[FLG_Z] = (md_lo == '0);
        end else begin
            md_flags[FLG_C] = (md_hi != '0);
            md_flags[FLG_V] = (md_hi != '0);
            md_flags[FLG_Z] = ({md_hi, md_lo} == '0);
        end
    end

    always_comb begin
        arith   = 1'b0;
        sub     = 1'b0;
        ci      = 1'b0;
        opb     = b;
        set_lf  = 1'b0;
        lres    = '0;
        shc     = 1'b0;
        c_res   = '0;
        c_hi    = '0;
        c_flags = flags;
        c_err   = 1'b0;
        case (op)
            OP_ADD:   arith = 1'b1;
            OP_ADC:   begin arith = 1'b1; ci = flags[FLG_C]; end
            OP_SUB,
            OP_CMP:   begin arith = 1'b1; sub = 1'b1; end
            OP_SBB:   begin arith = 1'b1; sub = 1'b1; ci = flags[FLG_C]; end
            OP_INC:   begin arith = 1'b1; opb = WIDTH'(1); end
            OP_DEC:   begin arith = 1'b1; sub = 1'b1; opb = WIDTH'(1); end
            OP_AND:   begin set_lf = 1'b1; lres = a & b; end
            OP_OR:    begin set_lf = 1'b1; lres = a | b; end
            OP_XOR:   begin set_lf = 1'b1; lres = a ^ b; end
            OP_NOT:   begin set_lf = 1'b1; lres = ~a; end
            OP_SHL:   begin set_lf = 1'b1; lres = {a[WIDTH-2:0], 1'b0};      shc = a[WIDTH-1]; end
            OP_SHR:   begin set_lf = 1'b1; lres = {1'b0, a[WIDTH-1:1]};      shc = a[0]; end
            OP_ROL:   begin set_lf = 1'b1; lres = {a[WIDTH-2:0], a[WIDTH-1]}; shc = a[WIDTH-1]; end
            OP_ROR:   begin set_lf = 1'b1; lres = {a[0], a[WIDTH-1:1]};      shc = a[0]; end
            OP_PASS:  c_res = a;
            OP_LOAD:  c_res = data_in;
            OP_STORE: c_res = a;
            OP_DIV: begin
                if (MD_EN != 0) begin
                    c_res   = '1;
                    c_hi    = a;
                    c_flags = 4'b0000;
                    c_flags[FLG_V] = 1'b1;
                end else begin
                    c_err = 1'b1;
                end
            end
            default:  c_err = 1'b1;
        endcase

        ext = sub ? ({1'b0, a} - {1'b0, opb} - {{WIDTH{1'b0}}, ci})
                  : ({1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, ci});

        if (arith) begin
            c_res          = (op == OP_CMP) ? '0 : ext[WIDTH-1:0];
            c_flags[FLG_C] = ext[WIDTH];
            c_flags[FLG_Z] = (ext[WIDTH-1:0] == '0);
            c_flags[FLG_S] = ext[WIDTH-1];
            c_flags[FLG_V] = sub ? ((a[WIDTH-1] != opb[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]))
                                 : ((a[WIDTH-1] == opb[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]));
        end
        if (set_lf) begin
            c_res          = lres;
            c_flags[FLG_C] = shc;
            c_flags[FLG_Z] = (lres == '0);
            c_flags[FLG_S] = lres[WIDTH-1];
            c_flags[FLG_V] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_start) state_d = ST_BUSY;
            ST_BUSY: if (md_fire)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            res_hi    <= '0;
            data_out  <= '0;
            flags     <= '0;
            err       <= 1'b0;
            busy_div  <= 1'b0;
        end else if (accept && !is_md) begin
            out_valid <= 1'b1;
            result    <= c_res;
            res_hi    <= c_hi;
            flags     <= c_flags;
            err       <= c_err;
            if (op == OP_STORE) data_out <= a;
        end else if (accept) begin
            // slot was free or consumed on this edge; the product arrives later
            out_valid <= 1'b0;
            busy_div  <= md_is_div;
        end else if (md_fire) begin
            out_valid <= 1'b1;
            result    <= md_lo;
            res_hi    <= md_hi;
            flags     <= md_flags;
            err       <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
